key_event_fifo: RTL and testbench

//   Buffers decoded keypad events downstream of the keypad scan/debounce front end. Each

---
 rtl/key_event_fifo_if.sv | 14 +
 rtl/key_event_fifo.sv | 111 +++++++++++
 tb/tb_key_event_fifo.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/key_event_fifo_if.sv
// Keypad event stream: key strobe/code/held in, valid/ready code stream out.
interface key_event_fifo_if;
  logic       key_valid_i;
  logic [3:0] key_code_i;
  logic       key_held_i;
  logic       out_valid_o;
  logic [3:0] out_code_o;
  logic       out_ready_i;

  modport slave  (input  key_valid_i, key_code_i, key_held_i, out_ready_i,
                  output out_valid_o, out_code_o);
  modport master (output key_valid_i, key_code_i, key_held_i, out_ready_i,
                  input  out_valid_o, out_code_o);
endinterface

// File: rtl/key_event_fifo.sv
// FWFT FIFO for decoded key events with sticky overflow flag.
// Define KEY_AUTOREPEAT_EN to add typematic repeat of a held key.
module key_event_fifo #(
  parameter int DEPTH         = 8,
  parameter int REPEAT_DELAY  = 3_000_000,
  parameter int REPEAT_PERIOD = 600_000
) (
  input  logic                       clk6MHz,
  input  logic                       rstn,
  key_event_fifo_if.slave            kif,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  input  logic                       clr_ovf_i
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          rpt_push;
  logic [3:0]    push_code;
  logic          push, pop, full, wr_en, drop;

  assign full  = (count_o == CNTW'(DEPTH));
  assign push  = kif.key_valid_i | rpt_push;
  assign pop   = kif.out_valid_o & kif.out_ready_i;
  // a pop in the same cycle frees the slot the push needs
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign kif.out_valid_o = (count_o != '0);
  assign kif.out_code_o  = kif.out_valid_o ? mem[rd_ptr] : 4'h0;

  always_ff @(posedge clk6MHz)
    if (wr_en) mem[wr_ptr] <= push_code;

  always_ff @(posedge clk6MHz) begin
    if (!rstn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
      if (drop)           overflow_o <= 1'b1;
      else if (clr_ovf_i) overflow_o <= 1'b0;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_st_t;
  rpt_st_t       st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    code_q, code_nx;

  always_ff @(posedge clk6MHz) begin
    if (!rstn) begin
      st     <= IDLE;
      cnt    <= '0;
      code_q <= 4'h0;
    end else begin
      st     <= st_nx;
      cnt    <= cnt_nx;
      code_q <= code_nx;
    end
  end

  // a fresh strobe always restarts the delay and masks any repeat due now
  always_comb begin
    st_nx    = st;
    cnt_nx   = cnt;
    code_nx  = code_q;
    rpt_push = 1'b0;
    if (kif.key_valid_i) begin
      code_nx = kif.key_code_i;
      cnt_nx  = CW'(REPEAT_DELAY - 1);
      st_nx   = DELAY;
    end else begin
      case (st)
        DELAY, REPEAT: begin
          if (!kif.key_held_i) begin
            st_nx  = IDLE;
            cnt_nx = '0;
          end else if (cnt == '0) begin
            rpt_push = 1'b1;
            cnt_nx   = CW'(REPEAT_PERIOD - 1);
            st_nx    = REPEAT;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign push_code = kif.key_valid_i ? kif.key_code_i : code_q;
`else
  assign rpt_push  = 1'b0;
  assign push_code = kif.key_code_i;
`endif
endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo (DEPTH=4, REPEAT_DELAY=10, REPEAT_PERIOD=4).
module tb_key_event_fifo;
  logic       clk6MHz = 1'b0;
  logic       rstn;
  logic       clr_ovf_i;
  logic [2:0] count_o;
  logic       overflow_o;
  int         total = 0;
  int         passed = 0;

  key_event_fifo_if kif();

  key_event_fifo #(.DEPTH(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut (
    .clk6MHz(clk6MHz), .rstn(rstn), .kif(kif),
    .count_o(count_o), .overflow_o(overflow_o), .clr_ovf_i(clr_ovf_i)
  );

  always #5 clk6MHz = ~clk6MHz;

  // advance one edge, then settle 1 time unit so outputs are sampled off the edge
  task automatic step();
    @(posedge clk6MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [3:0] code, input logic rdy);
    kif.key_valid_i = 1'b1;
    kif.key_code_i  = code;
    kif.out_ready_i = rdy;
    step();
    kif.key_valid_i = 1'b0;
    kif.out_ready_i = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, kif.out_code_o}, {28'd0, exp});
    kif.out_ready_i = 1'b1;
    step();
    kif.out_ready_i = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; clr_ovf_i = 1'b0;
    kif.key_valid_i = 1'b0; kif.key_code_i = 4'h0;
    kif.key_held_i = 1'b0;  kif.out_ready_i = 1'b0;
    step(); step();
    rstn = 1'b1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_valid", 32'(kif.out_valid_o), 0);
    chk("rst_code",  32'(kif.out_code_o), 0);
    chk("rst_ovf",   32'(overflow_o), 0);

    // 1: single push, FWFT presentation
    push(4'h3, 1'b0);
    chk("t1_valid", 32'(kif.out_valid_o), 1);
    chk("t1_code",  32'(kif.out_code_o), 3);
    chk("t1_count", 32'(count_o), 1);
    pop_chk("t1_pop", 4'h3);
    chk("t1_empty_count", 32'(count_o), 0);
    chk("t1_empty_code",  32'(kif.out_code_o), 0);

    // empty + push + ready: only writes
    push(4'hE, 1'b1);
    chk("empty_pushpop_count", 32'(count_o), 1);
    pop_chk("empty_pushpop_code", 4'hE);

    // 2: overflow on fifth push, drain order
    for (int i = 1; i <= 5; i++) push(4'(i), 1'b0);
    chk("t2_count", 32'(count_o), 4);
    chk("t2_ovf",   32'(overflow_o), 1);
    clr_ovf_i = 1'b1; step(); clr_ovf_i = 1'b0;
    chk("t2_clr", 32'(overflow_o), 0);
    for (int i = 1; i <= 4; i++) pop_chk("t2_drain", 4'(i));
    chk("t2_drained", 32'(count_o), 0);

    // 3: full, push with pop in same cycle
    for (int i = 1; i <= 4; i++) push(4'(i), 1'b0);
    push(4'hA, 1'b1);
    chk("t3_count", 32'(count_o), 4);
    chk("t3_head",  32'(kif.out_code_o), 2);
    chk("t3_ovf",   32'(overflow_o), 0);
    pop_chk("t3_d0", 4'h2);
    pop_chk("t3_d1", 4'h3);
    pop_chk("t3_d2", 4'h4);
    pop_chk("t3_tail", 4'hA);

    // 4: overflow set wins over clear
    for (int i = 5; i <= 8; i++) push(4'(i), 1'b0);
    push(4'h9, 1'b0);
    chk("t4_ovf_set", 32'(overflow_o), 1);
    clr_ovf_i = 1'b1;
    push(4'h9, 1'b0);
    chk("t4_ovf_wins", 32'(overflow_o), 1);
    chk("t4_count", 32'(count_o), 4);
    step();
    clr_ovf_i = 1'b0;
    chk("t4_ovf_clr", 32'(overflow_o), 0);
    chk("t4_head", 32'(kif.out_code_o), 5);

    // 5: reset discards contents
    rstn = 1'b0; step(); rstn = 1'b1;
    push(4'h7, 1'b0);
    chk("t5_pre", 32'(count_o), 1);
    rstn = 1'b0; step(); rstn = 1'b1;
    chk("t5_count", 32'(count_o), 0);
    chk("t5_valid", 32'(kif.out_valid_o), 0);
    chk("t5_code",  32'(kif.out_code_o), 0);

    // 6: held key, consumer always ready; out_valid after edge t0+k marks a push at k
    kif.out_ready_i = 1'b1;
    kif.key_held_i  = 1'b1;
    kif.key_valid_i = 1'b1;
    kif.key_code_i  = 4'hC;
    step();
    kif.key_valid_i = 1'b0;
    kif.key_code_i  = 4'h0;
    chk("t6_k0_valid", 32'(kif.out_valid_o), 1);
    chk("t6_k0_code",  32'(kif.out_code_o), 32'hC);
    for (int k = 1; k < 30; k++) begin
      logic e;
      step();
`ifdef KEY_AUTOREPEAT_EN
      e = (k >= 10) && (((k - 10) % 4) == 0);
`else
      e = 1'b0;
`endif
      chk($sformatf("t6_k%0d_valid", k), 32'(kif.out_valid_o), 32'(e));
      if (e) chk($sformatf("t6_k%0d_code", k), 32'(kif.out_code_o), 32'hC);
    end
    kif.key_held_i = 1'b0;
    for (int k = 30; k < 40; k++) begin
      step();
      chk($sformatf("t6_rel%0d_valid", k), 32'(kif.out_valid_o), 0);
    end
    chk("t6_ovf", 32'(overflow_o), 0);
    kif.out_ready_i = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
